// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator: type codes, major opcodes and the opcode decoder.
package imm_gen_pipe_pkg;

    localparam logic [2:0] TYPE_I   = 3'd0;
    localparam logic [2:0] TYPE_B   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_U   = 3'd3;
    localparam logic [2:0] TYPE_J   = 3'd4;
    localparam logic [2:0] TYPE_SH  = 3'd5;
    localparam logic [2:0] TYPE_CSR = 3'd6;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [2:0] decode_type(input logic [31:0] instr);
        logic [2:0] funct3;
        funct3 = instr[14:12];
        case (instr[6:0])
            OP_LOAD, OP_JALR:  decode_type = TYPE_I;
            OP_IMM:            decode_type = (funct3 == 3'b001 || funct3 == 3'b101) ? TYPE_SH : TYPE_I;
            OP_SYSTEM:         decode_type = funct3[2] ? TYPE_CSR : TYPE_I;
            OP_STORE:          decode_type = TYPE_S;
            OP_BRANCH:         decode_type = TYPE_B;
            OP_LUI, OP_AUIPC:  decode_type = TYPE_U;
            OP_JAL:            decode_type = TYPE_J;
            default:           decode_type = TYPE_ILL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational (instr, type) -> (extended immediate, err). Illegal type yields imm = 0.
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // The opcode field never contributes immediate bits.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_type)
            TYPE_I:   imm = XLEN'($signed(instr[31:20]));
            TYPE_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            TYPE_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            TYPE_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            TYPE_U:   imm = XLEN'($signed({instr[31:12], 12'h000}));
            TYPE_SH:  imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            TYPE_CSR: imm = XLEN'(instr[19:15]);
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry output FIFO. Define IMM_GEN_PIPE_ERRCNT_EN to build the
// saturating error counter; otherwise err_cnt is tied to zero.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_err,
    output logic [15:0]     err_cnt
);

    logic [2:0]      res_type;
    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    assign res_type = (AUTO_DECODE != 0) ? decode_type(in_instr) : in_type;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr    (in_instr),
        .imm_type (res_type),
        .imm      (ext_imm),
        .err      (ext_err)
    );

    logic [XLEN-1:0] imm_q  [2];
    logic [2:0]      type_q [2];
    logic            err_q  [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    // Both handshake flags come from count alone, so out_ready never reaches in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm  = imm_q[rd_ptr];
    assign out_type = type_q[rd_ptr];
    assign out_err  = err_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]  <= '0;
                type_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                imm_q[wr_ptr]  <= ext_imm;
                type_q[wr_ptr] <= res_type;
                err_q[wr_ptr]  <= ext_err;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IMM_GEN_PIPE_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Flush deliberately leaves the counter alone: it counts accepted entries, not delivered ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (push && ext_err && !flush && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter AUTO_DECODE, 1, 1 = type derived from opcode, 0 = type taken from in_type.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  in_instr/in_type valid.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_instr  input  32  full RISC-V instruction word.
REQ-009 in_type  input  3  immediate type; used only when AUTO_DECODE=0.
REQ-010 out_valid  output  1  out_* holds a valid entry.
REQ-011 out_ready  input  1  consumer accepts the entry.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_type  output  3  resolved immediate type.
REQ-014 out_err  output  1  type illegal or opcode undecodable; out_imm = 0.
REQ-015 err_cnt  output  16  count of entries accepted with err set.

Function
REQ-016 Type codes: I=0, B=1, S=2, U=3, J=4, SH=5, CSR=6 (zimm), 7 = illegal.
REQ-017 I: instr[31:20]; S: {instr[31:25],instr[11:7]}; B: {instr[31],instr[7],instr[30:25],instr[11:8],0}; J: {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended to XLEN.
REQ-018 U: {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-019 SH: zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64; CSR: zero-extended instr[19:15].
REQ-020 Auto-decode on instr[6:0]: 0000011/1100111 -> I; 0010011 -> SH if funct3 is 001 or 101, else I; 1110011 -> CSR if funct3[2]=1, else I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; any other -> 7 with err.
REQ-021 Two-entry FIFO buffer with 2-bit occupancy count 0..2; immediate computed before write, stored with type and err.
REQ-022 in_ready = (count != 2); driven from registered state only, with no combinational path from out_ready.
REQ-023 Push when in_valid && in_ready; pop when out_valid && out_ready; out_valid = (count != 0).
REQ-024 Latency: an entry pushed into an empty buffer is presented on out_* the next cycle.
REQ-025 Push and pop in the same cycle leave count unchanged and preserve order.
REQ-026 out_* stable while out_valid && !out_ready.
REQ-027 flush empties the buffer next cycle, takes priority over push and pop in the same cycle, and does not alter err_cnt.
REQ-028 err_cnt increments on each push with err=1 and saturates at 0xFFFF.

Reset
REQ-029 rst_n low: count=0, out_valid=0, out_imm=0, out_type=0, out_err=0, err_cnt=0; in_ready=1 one cycle after release.
REQ-030 Assertion mid-transfer drops all buffered entries with no partial output.

Configuration
REQ-031 Macro IMM_GEN_PIPE_ERRCNT_EN defined: err_cnt counter present per REQ-028.
REQ-032 Macro undefined: no counter flops; err_cnt tied to 0; all other behaviour identical.

Structure
REQ-033 Shared package holds the type-code constants (REQ-016) and opcode constants (REQ-020).
REQ-034 One combinational sub-module, imm_extract, maps (instr, type) to (imm, err); the FIFO and counter are in imm_gen_pipe.

Verification
REQ-035 AUTO_DECODE=1, XLEN=32, instr 0xFFC98993 (addi -4), out_ready=1 -> next cycle out_imm=0xFFFFFFFC, type 0, err 0.
REQ-036 instr 0x02540063 (beq +32) -> out_imm=0x00000020, type 1; instr 0x0000006F then 0x0200006F (jal) -> 0, then 0x20, in order.
REQ-037 XLEN=64, instr 0x80000537 (lui) -> out_imm=0xFFFFFFFF80000000; slli 0x03F51513 -> out_imm=0x3F, type 5.
REQ-038 out_ready=0, three consecutive pushes -> in_ready low after the second push; third not accepted; out_imm held; release out_ready -> two entries drained in order.
REQ-039 Opcode 0x7F five times with IMM_GEN_PIPE_ERRCNT_EN -> out_err=1, out_imm=0, err_cnt=5; same stimulus with the macro undefined -> err_cnt=0.
REQ-040 Buffer full, then flush and in_valid asserted in the same cycle -> count=0 next cycle, nothing pushed; rst_n low mid-stream -> out_valid=0 immediately.
